// File: rtl/ntt_pkg.sv
// Shared modular-arithmetic helpers and coefficient type for the radix-2 NTT engine.
// The 64-bit helpers assume operands below 2^32, so products never overflow.
package ntt_pkg;

    localparam int unsigned COEF_W = 32;
    typedef logic [COEF_W-1:0] coef_t;

    function automatic logic [63:0] mod_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] q);
        logic [63:0] s;
        s = a + b;
        return (s >= q) ? (s - q) : s;
    endfunction

    function automatic logic [63:0] mod_sub(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] q);
        return (a >= b) ? (a - b) : (a + (q - b));
    endfunction

    function automatic logic [63:0] mod_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] q);
        return (a * b) % q;
    endfunction

    function automatic logic [63:0] mod_pow(input logic [63:0] base, input logic [63:0] e,
                                            input logic [63:0] q);
        logic [63:0] result;
        logic [63:0] b;
        logic [63:0] ee;
        result = 64'd1 % q;
        b      = base % q;
        ee     = e;
        for (int i = 0; i < 64; i++) begin
            result = ee[0] ? mod_mul(result, b, q) : result;
            b      = mod_mul(b, b, q);
            ee     = ee >> 1;
        end
        return result;
    endfunction

    // Fermat inverse: q is prime.
    function automatic logic [63:0] mod_inv(input logic [63:0] a, input logic [63:0] q);
        return mod_pow(a, q - 64'd2, q);
    endfunction

    function automatic int unsigned bit_rev(input int unsigned idx, input int unsigned bits);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 32'd0; i < bits; i++) begin
            r = (r << 1) | ((idx >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational Cooley-Tukey butterfly over Z_Q: (a, b, w) -> (a + w*b, a - w*b) mod Q.
module ntt_butterfly #(
    parameter int unsigned  W = 32,
    parameter logic [W-1:0] Q = 32'd134221489
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_w,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_diff
);

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_t;
    logic [W:0]     w_sum;

    // Full-width product reduction followed by single-step add/sub correction.
    always_comb begin
        w_prod = {{W{1'b0}}, i_w} * {{W{1'b0}}, i_b};
        w_t    = W'(w_prod % {{W{1'b0}}, Q});
        w_sum  = {1'b0, i_a} + {1'b0, w_t};
        if (w_sum >= {1'b0, Q}) begin
            o_sum = W'(w_sum - {1'b0, Q});
        end else begin
            o_sum = w_sum[W-1:0];
        end
        // Q < 2^(W-1) keeps a + (Q - t) inside W bits.
        if (i_a >= w_t) begin
            o_diff = i_a - w_t;
        end else begin
            o_diff = i_a + (Q - w_t);
        end
    end

endmodule

// File: rtl/ntt_radix2_pipelined.sv
// Fully pipelined radix-2 DIT NTT / scaled inverse NTT, one N-point vector per cycle,
// one register stage per butterfly stage. Supports W up to 32.
module ntt_radix2_pipelined
    import ntt_pkg::*;
#(
    parameter int unsigned  W         = 32,
    parameter int unsigned  N         = 8,
    parameter logic [W-1:0] Modulus_Q = 32'd134221489,
    parameter logic [W-1:0] OMEGA     = 32'd10606137
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_valid_in,
    input  logic         iNTT_mode,
    input  logic [W-1:0] Data_in  [0:N-1],
    output logic [W-1:0] Data_out [0:N-1],
    output logic         data_valid_out,
    output logic         mode_out
);

    localparam int unsigned  LOG_N     = $clog2(N);
    localparam logic [63:0]  Q64       = 64'(Modulus_Q);
    localparam logic [W-1:0] OMEGA_INV = W'(mod_inv(64'(OMEGA), Q64));
    localparam logic [W-1:0] N_INV     = W'(mod_inv(64'(N), Q64));

    typedef logic [N/2-1:0][W-1:0] tw_table_t;

    function automatic tw_table_t twiddle_table(input logic [63:0] root);
        tw_table_t tbl;
        for (int k = 0; k < N/2; k++) begin
            tbl[k] = W'(mod_pow(root, 64'(k), Q64));
        end
        return tbl;
    endfunction

    localparam tw_table_t TW_FWD = twiddle_table(64'(OMEGA));
    localparam tw_table_t TW_INV = twiddle_table(64'(OMEGA_INV));

    for (genvar s = 0; s < LOG_N; s++) begin : g_stage
        // Stage span m = 2^(s+1); its root omega^(N/m) is table entry N/m.
        localparam int unsigned HALF      = 32'd1 << s;
        localparam int unsigned TW_STRIDE = N >> (s + 1);

        logic         w_vin;
        logic         w_min;
        logic [W-1:0] w_in  [0:N-1];
        logic [W-1:0] w_bf  [0:N-1];
        logic [W-1:0] w_res [0:N-1];
        logic         r_valid;
        logic         r_mode;
        logic [W-1:0] r_data [0:N-1];

        if (s == 0) begin : g_first
            assign w_vin = data_valid_in;
            assign w_min = iNTT_mode;
            // Bit-reversed input order plus reduction of arbitrary W-bit words.
            for (genvar i = 0; i < N; i++) begin : g_in
                localparam int unsigned SRC = bit_rev(i, LOG_N);
                assign w_in[i] = Data_in[SRC] % Modulus_Q;
            end
        end else begin : g_next
            assign w_vin = g_stage[s-1].r_valid;
            assign w_min = g_stage[s-1].r_mode;
            assign w_in  = g_stage[s-1].r_data;
        end

        for (genvar b = 0; b < N/2; b++) begin : g_bf
            localparam int unsigned J      = b % HALF;
            localparam int unsigned A_IDX  = (b / HALF) * 2 * HALF + J;
            localparam int unsigned B_IDX  = A_IDX + HALF;
            localparam int unsigned TW_IDX = J * TW_STRIDE;

            logic [W-1:0] w_tw;
            assign w_tw = w_min ? TW_INV[TW_IDX] : TW_FWD[TW_IDX];

            ntt_butterfly #(
                .W (W),
                .Q (Modulus_Q)
            ) u_bf (
                .i_a    (w_in[A_IDX]),
                .i_b    (w_in[B_IDX]),
                .i_w    (w_tw),
                .o_sum  (w_bf[A_IDX]),
                .o_diff (w_bf[B_IDX])
            );
        end

        for (genvar i = 0; i < N; i++) begin : g_res
            if (s == LOG_N - 1) begin : g_scale
                assign w_res[i] = w_min ? W'(mod_mul(64'(w_bf[i]), 64'(N_INV), Q64)) : w_bf[i];
            end else begin : g_pass
                assign w_res[i] = w_bf[i];
            end
        end

        // Valid/mode shift every cycle; data loads only with a valid vector.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_mode  <= 1'b0;
                for (int i = 0; i < N; i++) begin
                    r_data[i] <= '0;
                end
            end else begin
                r_valid <= w_vin;
                r_mode  <= w_min;
                if (w_vin) begin
                    for (int i = 0; i < N; i++) begin
                        r_data[i] <= w_res[i];
                    end
                end
            end
        end
    end

    assign Data_out       = g_stage[LOG_N-1].r_data;
    assign data_valid_out = g_stage[LOG_N-1].r_valid;
    assign mode_out       = g_stage[LOG_N-1].r_mode;

endmodule

// File: tb/tb_ntt_radix2_pipelined.sv
// Scoreboard bench for ntt_radix2_pipelined: expected vectors come from spec constants
// or a direct O(N^2) transform model and are checked when the DUT emits them.
module tb_ntt_radix2_pipelined;
    import ntt_pkg::*;

    localparam int unsigned    W     = 32;
    localparam int unsigned    N     = 8;
    localparam int unsigned    LAT   = 3;
    localparam longint unsigned Q     = 64'd134221489;
    localparam longint unsigned OMEGA = 64'd10606137;

    typedef logic [N-1:0][W-1:0] pvec_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   data_valid_in;
    logic   iNTT_mode;
    coef_t  Data_in  [0:N-1];
    logic [W-1:0] Data_out [0:N-1];
    logic   data_valid_out;
    logic   mode_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    pvec_t exp_data_q[$];
    logic  exp_mode_q[$];
    int    exp_cyc_q[$];
    pvec_t mon_exp;
    logic  mon_mode;
    int    mon_cyc;
    pvec_t last_exp = '0;

    ntt_radix2_pipelined #(
        .W         (W),
        .N         (N),
        .Modulus_Q (32'd134221489),
        .OMEGA     (32'd10606137)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_valid_in  (data_valid_in),
        .iNTT_mode      (iNTT_mode),
        .Data_in        (Data_in),
        .Data_out       (Data_out),
        .data_valid_out (data_valid_out),
        .mode_out       (mode_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned mpow(input longint unsigned b, input longint unsigned e);
        longint unsigned r  = 64'd1;
        longint unsigned bb = b % Q;
        longint unsigned ee = e;
        while (ee != 64'd0) begin
            if ((ee & 64'd1) != 64'd0) r = (r * bb) % Q;
            bb = (bb * bb) % Q;
            ee = ee >> 1;
        end
        return r;
    endfunction

    // Direct definition of the cyclic transform, natural order in and out.
    function automatic pvec_t ntt_model(input pvec_t x, input logic inv);
        pvec_t y;
        longint unsigned root = inv ? mpow(OMEGA, Q - 64'd2) : OMEGA;
        longint unsigned ninv = mpow(64'(N), Q - 64'd2);
        for (int k = 0; k < N; k++) begin
            longint unsigned acc = 64'd0;
            for (int n = 0; n < N; n++) begin
                longint unsigned xn = 64'(x[n]) % Q;
                acc = (acc + xn * mpow(root, 64'((n * k) % N))) % Q;
            end
            if (inv) acc = (acc * ninv) % Q;
            y[k] = W'(acc);
        end
        return y;
    endfunction

    task automatic send(input pvec_t x, input logic m, input pvec_t exp);
        for (int i = 0; i < N; i++) Data_in[i] = x[i];
        iNTT_mode     = m;
        data_valid_in = 1'b1;
        exp_data_q.push_back(exp);
        exp_mode_q.push_back(m);
        exp_cyc_q.push_back(cyc + LAT);
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        data_valid_in = 1'b0;
        iNTT_mode     = 1'b0;
        while (exp_data_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 64'(exp_data_q.size()), 64'd0);
    endtask

    // Output monitor: every valid pulse must match the oldest outstanding vector.
    always @(negedge clk) begin
        if (data_valid_out === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                mon_exp  = exp_data_q.pop_front();
                mon_mode = exp_mode_q.pop_front();
                mon_cyc  = exp_cyc_q.pop_front();
                last_exp = mon_exp;
                check("latency", 64'(cyc), 64'(mon_cyc));
                check("mode_out", 64'(mode_out), 64'(mon_mode));
                for (int k = 0; k < N; k++)
                    check($sformatf("Data_out[%0d]", k), 64'(Data_out[k]), 64'(mon_exp[k]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pvec_t imp, ones, sh, alt, sumv, fwd, c5, c40, inv5, rv;
        logic  rm;

        reset         = 1'b1;
        data_valid_in = 1'b0;
        iNTT_mode     = 1'b0;
        for (int i = 0; i < N; i++) Data_in[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(data_valid_out), 64'd0);
        check("rst_mode", 64'(mode_out), 64'd0);
        for (int k = 0; k < N; k++) check($sformatf("rst_data[%0d]", k), 64'(Data_out[k]), 64'd0);

        imp = '0; imp[0] = 32'd1;
        sh  = '0; sh[4]  = 32'd1;
        for (int k = 0; k < N; k++) begin
            ones[k] = 32'd1;
            alt[k]  = (k % 2 == 0) ? 32'd1 : 32'd134221488;
            c5[k]   = 32'd5;
        end
        c40  = '0; c40[0]  = 32'd40;
        inv5 = '0; inv5[0] = 32'd5;
        sumv = '0;
        for (int k = 0; k < 5; k++) sumv[k] = 32'(123412341 + k);

        send(imp, 1'b0, ones);
        drain();
        send(sh, 1'b0, alt);
        drain();

        fwd = ntt_model(sumv, 1'b0);
        send(sumv, 1'b0, fwd);
        drain();
        send(fwd, 1'b1, sumv);
        drain();

        send(c5, 1'b0, c40);
        drain();
        send(c40, 1'b1, c5);
        drain();

        // Back-to-back vectors with a mode change between them.
        send(imp, 1'b0, ones);
        send(c5, 1'b1, inv5);
        drain();
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) check($sformatf("hold[%0d]", k), 64'(Data_out[k]), 64'(last_exp[k]));

        // Unreduced random words in a mixed-mode burst.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) rv[k] = $urandom;
            rm = 1'($urandom_range(0, 1));
            send(rv, rm, ntt_model(rv, rm));
        end
        drain();

        // Reset one cycle after a valid vector, with valid held high during reset.
        for (int k = 0; k < N; k++) Data_in[k] = 32'(k + 7);
        iNTT_mode     = 1'b0;
        data_valid_in = 1'b1;
        @(negedge clk);
        reset     = 1'b1;
        iNTT_mode = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        data_valid_in = 1'b0;
        iNTT_mode     = 1'b0;
        for (int k = 0; k < N; k++) check($sformatf("rst_mid_data[%0d]", k), 64'(Data_out[k]), 64'd0);
        for (int c = 0; c < 6; c++) begin
            check("rst_mid_valid", 64'(data_valid_out), 64'd0);
            @(negedge clk);
        end
        check("rst_mid_mode", 64'(mode_out), 64'd0);

        send(imp, 1'b0, ones);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
